mpu_sample_sequencer: RTL

//  Autonomous transaction sequencer for i2c_master driving the MPU sensor. After run is raised it wakes the device
//  (PWR_MGMT_1=0x00) and checks WHO_AM_I, then periodically reads TEMP/GYRO registers 0x41..0x48.
//  It assembles them into 16-bit samples with a valid pulse. Replaces manual register selection; sits between

---
 rtl/mpu_sample_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mpu_sample_sequencer.sv
// Autonomous i2c_master sequencer for the MPU sensor: wakes the device, verifies WHO_AM_I,
// then periodically bursts eight TEMP/GYRO register reads and publishes them as 16-bit samples.
module mpu_sample_sequencer #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h69,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h68,
    parameter int         PERIOD        = 1000,
    parameter int         TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        i2c_en,
    output logic [6:0]  i2c_slave_address,
    output logic        i2c_read_write,
    output logic [7:0]  i2c_register_address,
    output logic [7:0]  i2c_data_in,
    input  logic [7:0]  i2c_data_out,
    input  logic        i2c_done,
    output logic [15:0] temp,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PERIOD + 1);
    // The transaction is abandoned on the edge where the count would reach TIMEOUT,
    // so i2c_en stays high for exactly TIMEOUT cycles.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] P_MAX  = '1;

    localparam logic [7:0] REG_PWR_MGMT_1 = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I   = 8'h75;
    localparam logic [7:0] REG_FIRST_DATA = 8'h41;

    typedef enum logic [2:0] {
        IDLE, WAKE, CHECK_ID, GAP, READ, PUBLISH, WAIT_PERIOD, FAULT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   pcnt;
    logic [2:0]      idx;
    logic [7:0]      shadow [8];

    logic            in_txn;
    logic            next_is_txn;
    logic            txn_done;
    logic            txn_timeout;
    logic            period_up;
    logic            set_error;
    logic            burst_start;

    assign in_txn      = (state == WAKE) || (state == CHECK_ID) || (state == READ);
    assign next_is_txn = (state_next == WAKE) || (state_next == CHECK_ID) || (state_next == READ);
    // A done pulse only counts while a request is actually outstanding.
    assign txn_done    = in_txn && i2c_en && i2c_done;
    assign txn_timeout = in_txn && i2c_en && !i2c_done && (tcnt == T_LAST);
    assign period_up   = (pcnt >= P_LAST);
    assign busy        = (state != IDLE) && (state != FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        set_error   = 1'b0;
        burst_start = 1'b0;
        case (state)
            IDLE: if (run) state_next = WAKE;
            WAKE: begin
                if (txn_timeout) begin
                    set_error  = 1'b1;
                    state_next = FAULT;
                end else if (txn_done) begin
                    state_next = run ? CHECK_ID : IDLE;
                end
            end
            CHECK_ID: begin
                if (txn_timeout) begin
                    set_error  = 1'b1;
                    state_next = FAULT;
                end else if (txn_done) begin
                    if (i2c_data_out != WHO_AM_I_VAL) begin
                        set_error  = 1'b1;
                        state_next = FAULT;
                    end else if (run) begin
                        state_next  = GAP;
                        burst_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: state_next = run ? READ : IDLE;
            READ: begin
                if (txn_timeout) begin
                    set_error  = 1'b1;
                    state_next = FAULT;
                end else if (txn_done) begin
                    if (!run)            state_next = IDLE;
                    else if (idx == 3'd7) state_next = PUBLISH;
                    else                 state_next = GAP;
                end
            end
            PUBLISH: state_next = run ? WAIT_PERIOD : IDLE;
            WAIT_PERIOD: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (period_up) begin
                    state_next  = GAP;
                    burst_start = 1'b1;
                end
            end
            FAULT: if (!run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i2c_en               <= 1'b0;
            i2c_slave_address    <= '0;
            i2c_read_write       <= 1'b0;
            i2c_register_address <= '0;
            i2c_data_in          <= '0;
            tcnt                 <= '0;
            pcnt                 <= '0;
            idx                  <= '0;
            error                <= 1'b0;
            sample_valid         <= 1'b0;
            temp                 <= '0;
            gyro_x               <= '0;
            gyro_y               <= '0;
            gyro_z               <= '0;
        end else begin
            // Dropping en on the done edge leaves a one-cycle low gap before a back-to-back request.
            i2c_en <= next_is_txn && !txn_done && !txn_timeout;
            tcnt   <= i2c_en ? tcnt + 1'b1 : '0;

            if (next_is_txn && (state_next != state)) begin
                i2c_slave_address <= SLAVE_ADDRESS;
                case (state_next)
                    WAKE: begin
                        i2c_read_write       <= 1'b0;
                        i2c_register_address <= REG_PWR_MGMT_1;
                        i2c_data_in          <= 8'h00;
                    end
                    CHECK_ID: begin
                        i2c_read_write       <= 1'b1;
                        i2c_register_address <= REG_WHO_AM_I;
                    end
                    default: begin
                        i2c_read_write       <= 1'b1;
                        i2c_register_address <= REG_FIRST_DATA + {5'd0, idx};
                    end
                endcase
            end

            if (burst_start || (state_next == IDLE))          idx <= '0;
            else if ((state == READ) && txn_done && (idx != 3'd7)) idx <= idx + 1'b1;

            if (burst_start)        pcnt <= '0;
            else if (pcnt != P_MAX) pcnt <= pcnt + 1'b1;

            if ((state == IDLE) && (state_next == WAKE)) error <= 1'b0;
            else if (set_error)                          error <= 1'b1;

            sample_valid <= (state == PUBLISH);
            if (state == PUBLISH) begin
                temp   <= {shadow[0], shadow[1]};
                gyro_x <= {shadow[2], shadow[3]};
                gyro_y <= {shadow[4], shadow[5]};
                gyro_z <= {shadow[6], shadow[7]};
            end
        end
    end

    // NOTE: the shadow bytes carry no reset; outputs only load from them after a full burst rewrote all eight.
    always_ff @(posedge clk) begin
        if ((state == READ) && txn_done) shadow[idx] <= i2c_data_out;
    end

endmodule
